// File: rtl/axi_stream_header_arbiter.sv
// axi_stream_header_arbiter: round-robin scheduler sharing one header-insert port among NUM_REQ sources (optional watchdog: HDR_ARB_TIMEOUT_EN)
module axi_stream_header_arbiter #(
  parameter int DATA_WD = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD = $clog2(DATA_BYTE_WD),
  parameter int NUM_REQ = 4,
  parameter int REQ_ID_WD = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]        req_data,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0]   req_keep,
  input  logic [NUM_REQ*BYTE_CNT_WD-1:0]    req_byte_cnt,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              valid_insert,
  output logic [DATA_WD-1:0]                data_insert,
  output logic [DATA_BYTE_WD-1:0]           keep_insert,
  output logic [BYTE_CNT_WD-1:0]            byte_insert_cnt,
  input  logic                              ready_insert,
  input  logic                              mon_valid_out,
  input  logic                              mon_ready_out,
  input  logic                              mon_last_out,
  output logic [REQ_ID_WD-1:0]              grant_id,
  output logic                              busy,
  output logic                              pkt_done,
  output logic                              timeout_err
);
  typedef enum logic [1:0] {IDLE, OFFER, WAIT_LAST} state_t;
  state_t state, nxt;
  logic [REQ_ID_WD-1:0] rr_ptr, win, idx;
  logic hit, beat, last_beat, tmo;
  logic [DATA_WD-1:0] hd [NUM_REQ];
  logic [DATA_BYTE_WD-1:0] hk [NUM_REQ];
  logic [BYTE_CNT_WD-1:0] hc [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign hd[i] = req_data[i*DATA_WD +: DATA_WD];
    assign hk[i] = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign hc[i] = req_byte_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
  end
  assign beat = mon_valid_out & mon_ready_out;
  assign last_beat = state == WAIT_LAST && beat && mon_last_out;
  assign req_ready = (!rst && state == IDLE && hit) ? (NUM_REQ'(1) << win) : '0;
  // round-robin search: scanning downward lets the candidate closest to rr_ptr win
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = REQ_ID_WD'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end
`ifdef HDR_ARB_TIMEOUT_EN
  localparam int CNT_WD = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WD-1:0] cnt;
  // watchdog: counts consecutive beat-free cycles spent in WAIT_LAST
  always_ff @(posedge clk)
    cnt <= (rst || state != WAIT_LAST || beat) ? '0 : cnt + 1'b1;
  assign tmo = state == WAIT_LAST && !beat && cnt == CNT_WD'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  // next-state: grant, wait for insert acceptance, then hold until the owned packet's last beat
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = hit ? OFFER : IDLE;
      OFFER:     nxt = ready_insert ? WAIT_LAST : OFFER;
      WAIT_LAST: nxt = (last_beat || tmo) ? IDLE : WAIT_LAST;
      default:   nxt = IDLE;
    endcase
  end
  // registered outputs, header latch and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      valid_insert <= 1'b0;
      data_insert <= '0;
      keep_insert <= '0;
      byte_insert_cnt <= '0;
      grant_id <= '0;
      busy <= 1'b0;
      pkt_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      valid_insert <= nxt == OFFER;
      busy <= nxt != IDLE;
      pkt_done <= last_beat;
      timeout_err <= tmo;
      if (state == IDLE && hit) begin
        data_insert <= hd[win];
        keep_insert <= hk[win];
        byte_insert_cnt <= hc[win];
        grant_id <= win;
        rr_ptr <= (win == REQ_ID_WD'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end
endmodule
